// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - RV32I load/store unit with posted in-order store buffer
module riscv_lsu #(
    parameter int SB_DEPTH      = 4,
    parameter int XLEN          = 32,
    parameter int DMEM_ADDR_BIT = 12
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_we,
    input  logic [2:0]                 i_req_funct3,
    input  logic [XLEN-1:0]            i_req_addr,
    input  logic [XLEN-1:0]            i_req_wdata,
    output logic                       o_rsp_valid,
    output logic [XLEN-1:0]            o_rsp_rdata,
    output logic                       o_rsp_err,
    output logic                       o_sb_empty,
    output logic [XLEN-1:0]            o_dmem_data,
    input  logic [XLEN-1:0]            i_dmem_data,
    output logic [DMEM_ADDR_BIT-3:0]   o_dmem_addr,
    output logic [XLEN/8-1:0]          o_dmem_byte_sel,
    output logic                       o_dmem_wr_en
);

    localparam int NB = XLEN / 8;
    localparam int PW = $clog2(SB_DEPTH);
    localparam int WA = DMEM_ADDR_BIT - 2;

    // Store buffer storage: ring of {word address, byte mask, lane-aligned data}
    logic [WA-1:0]       sb_addr [SB_DEPTH];
    logic [NB-1:0]       sb_mask [SB_DEPTH];
    logic [XLEN-1:0]     sb_data [SB_DEPTH];
    logic [SB_DEPTH-1:0] sb_vld;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [PW:0]         count;

    logic            req_err;
    logic [1:0]      byte_off;
    logic [WA-1:0]   req_waddr;
    logic            hazard;
    logic            full;
    logic            accept;
    logic            push;
    logic            load;
    logic            drain;
    logic [NB-1:0]   st_mask_base;
    logic [NB-1:0]   st_mask;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ld_ext;
    logic            unused_addr_bits;

    assign byte_off         = i_req_addr[1:0];
    assign req_waddr        = i_req_addr[DMEM_ADDR_BIT-1:2];
    assign unused_addr_bits = ^i_req_addr[XLEN-1:DMEM_ADDR_BIT];

    // Legality check: alignment per access size, and funct3 codes valid for the direction
    always_comb begin
        req_err = 1'b0;
        case (i_req_funct3)
            3'b000:  req_err = 1'b0;
            3'b100:  req_err = i_req_we;
            3'b001:  req_err = i_req_addr[0];
            3'b101:  req_err = i_req_we | i_req_addr[0];
            3'b010:  req_err = |i_req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Word-granular hazard: a load waits while any buffered store targets its word
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_vld[i] && (sb_addr[i] == req_waddr)) begin
                hazard = 1'b1;
            end
        end
    end

    assign full       = (count == (PW+1)'(SB_DEPTH));
    assign o_sb_empty = (count == '0);

    // Request acceptance: errors always go through, stores need space, loads need no hazard
    always_comb begin
        o_req_ready = 1'b0;
        if (i_rstn) begin
            if (req_err) begin
                o_req_ready = 1'b1;
            end else if (i_req_we) begin
                o_req_ready = !full;
            end else begin
                o_req_ready = !hazard;
            end
        end
    end

    assign accept = i_req_valid & o_req_ready;
    assign push   = accept & i_req_we & !req_err;
    assign load   = accept & !i_req_we & !req_err;
    assign drain  = i_rstn & !accept & !o_sb_empty;

    // Store formatting: size mask and data moved onto the addressed byte lanes
    always_comb begin
        st_mask_base = '1;
        case (i_req_funct3[1:0])
            2'b00:   st_mask_base = NB'(1);
            2'b01:   st_mask_base = NB'(3);
            default: st_mask_base = '1;
        endcase
        st_mask = st_mask_base << byte_off;
        st_data = i_req_wdata << {byte_off, 3'b000};
    end

    // Load formatting: pick the addressed lane and extend to XLEN
    always_comb begin
        lane   = i_dmem_data >> {byte_off, 3'b000};
        ld_ext = lane;
        case (i_req_funct3)
            3'b000:  ld_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    // Data memory port: a load read takes priority, otherwise drain the head store
    always_comb begin
        o_dmem_wr_en    = 1'b0;
        o_dmem_addr     = '0;
        o_dmem_byte_sel = '0;
        o_dmem_data     = '0;
        if (load) begin
            o_dmem_addr     = req_waddr;
            o_dmem_byte_sel = '1;
        end else if (drain) begin
            o_dmem_wr_en    = 1'b1;
            o_dmem_addr     = sb_addr[rd_ptr];
            o_dmem_byte_sel = sb_mask[rd_ptr];
            o_dmem_data     = sb_data[rd_ptr];
        end
    end

    // Store buffer pointers, occupancy and per-entry valid bits
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            sb_vld <= '0;
        end else if (push) begin
            sb_vld[wr_ptr] <= 1'b1;
            wr_ptr         <= wr_ptr + 1'b1;
            count          <= count + 1'b1;
        end else if (drain) begin
            sb_vld[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + 1'b1;
            count          <= count - 1'b1;
        end
    end

    // Store buffer payload; contents are only meaningful where sb_vld is set
    always_ff @(posedge i_clk) begin
        if (push) begin
            sb_addr[wr_ptr] <= req_waddr;
            sb_mask[wr_ptr] <= st_mask;
            sb_data[wr_ptr] <= st_data;
        end
    end

    // Response register: one-cycle pulse for every accepted request
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            o_rsp_valid <= accept;
            o_rsp_err   <= accept & req_err;
            o_rsp_rdata <= load ? ld_ext : '0;
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - scoreboard testbench for riscv_lsu
module tb_riscv_lsu;

    localparam int XLEN  = 32;
    localparam int AB    = 12;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sb_empty;
    logic [31:0] dmem_data;
    logic [31:0] dmem_rdata;
    logic [9:0]  dmem_addr;
    logic [3:0]  dmem_byte_sel;
    logic        dmem_wr_en;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [9:0]  addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    logic [31:0] mem [1024];

    riscv_lsu #(.SB_DEPTH(DEPTH), .XLEN(XLEN), .DMEM_ADDR_BIT(AB)) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_we        (req_we),
        .i_req_funct3    (req_funct3),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_rdata     (rsp_rdata),
        .o_rsp_err       (rsp_err),
        .o_sb_empty      (sb_empty),
        .o_dmem_data     (dmem_data),
        .i_dmem_data     (dmem_rdata),
        .o_dmem_addr     (dmem_addr),
        .o_dmem_byte_sel (dmem_byte_sel),
        .o_dmem_wr_en    (dmem_wr_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign dmem_rdata = mem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_byte_sel[b]) mem[dmem_addr][8*b +: 8] <= dmem_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response and dmem-write monitors
    always @(negedge clk) begin
        rsp_t er;
        wr_t  ew;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                er = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, er.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, er.err});
                chk("rsp_latency", cyc, er.cyc);
            end
        end
        if (dmem_wr_en) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_dmem_write", {22'd0, dmem_addr}, 32'hFFFFFFFF);
            end else begin
                ew = wr_q.pop_front();
                chk("drain_addr", {22'd0, dmem_addr}, {22'd0, ew.addr});
                chk("drain_sel", {28'd0, dmem_byte_sel}, {28'd0, ew.sel});
                chk("drain_data", dmem_data, ew.data);
            end
        end
    end

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd_exp,
                        input logic err_exp, output int stalls);
        rsp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        stalls     = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            stalls++;
            if (stalls >= 50) begin
                chk("ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        e.rdata = rd_exp;
        e.err   = err_exp;
        e.cyc   = cyc + 1;
        rsp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [9:0] a, input logic [3:0] s, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.sel  = s;
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // Reset with a store presented
        rstn = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h300; req_wdata = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_wr_en", {31'd0, dmem_wr_en}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        req_valid = 1'b0;
        rstn = 1'b1;
        #1;
        chk("reset_sb_empty", {31'd0, sb_empty}, 32'd1);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        idle(2);

        // Word store, drain, then lane extraction
        expect_wr(10'h040, 4'b1111, 32'h80F17F02);
        send(1'b1, 3'b010, 32'h100, 32'h80F17F02, 32'h0, 1'b0, st);
        idle(2);
        send(1'b0, 3'b000, 32'h101, 32'h0, 32'h0000007F, 1'b0, st);
        send(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, st);
        send(1'b0, 3'b100, 32'h103, 32'h0, 32'h00000080, 1'b0, st);
        send(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF80F1, 1'b0, st);
        send(1'b0, 3'b101, 32'h102, 32'h0, 32'h000080F1, 1'b0, st);
        send(1'b0, 3'b010, 32'h100, 32'h0, 32'h80F17F02, 1'b0, st);
        chk("load_no_stall", st, 0);
        idle(1);

        // Sub-word stores
        expect_wr(10'h041, 4'b0010, 32'h0000AB00);
        expect_wr(10'h041, 4'b1100, 32'h12340000);
        send(1'b1, 3'b000, 32'h105, 32'h000000AB, 32'h0, 1'b0, st);
        send(1'b1, 3'b001, 32'h106, 32'h00001234, 32'h0, 1'b0, st);
        idle(3);
        send(1'b0, 3'b010, 32'h104, 32'h0, 32'h1234AB00, 1'b0, st);
        idle(2);

        // Full buffer stall, then load hazard on the newest entry
        for (int k = 0; k < 5; k++) begin
            expect_wr(10'(10'h080 + k), 4'b1111, 32'h11111111 * (k + 1));
        end
        for (int k = 0; k < 5; k++) begin
            send(1'b1, 3'b010, 32'h200 + 4 * k, 32'h11111111 * (k + 1), 32'h0, 1'b0, st);
            chk($sformatf("store%0d_stalls", k), st, (k == 4) ? 1 : 0);
        end
        send(1'b0, 3'b010, 32'h210, 32'h0, 32'h55555555, 1'b0, st);
        chk("hazard_stalls", st, 4);
        idle(2);

        // Illegal requests, including one while the buffer is full
        for (int k = 0; k < 4; k++) begin
            expect_wr(10'(10'h0C0 + k), 4'b1111, 32'hA0A0A0A0 + k);
        end
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 3'b010, 32'h300 + 4 * k, 32'hA0A0A0A0 + k, 32'h0, 1'b0, st);
        end
        send(1'b1, 3'b010, 32'h302, 32'hFFFFFFFF, 32'h0, 1'b1, st);
        chk("err_full_stalls", st, 0);
        send(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, st);
        chk("err_lw_stalls", st, 0);
        send(1'b1, 3'b001, 32'h101, 32'hFFFF, 32'h0, 1'b1, st);
        chk("err_sh_stalls", st, 0);
        send(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, st);
        send(1'b1, 3'b100, 32'h100, 32'h1, 32'h0, 1'b1, st);
        idle(6);
        chk("after_drain_empty", {31'd0, sb_empty}, 32'd1);

        // Mid-operation reset discards buffered stores
        send(1'b1, 3'b010, 32'h400, 32'h01020304, 32'h0, 1'b0, st);
        send(1'b1, 3'b000, 32'h405, 32'h05, 32'h0, 1'b0, st);
        send(1'b1, 3'b001, 32'h40A, 32'h0607, 32'h0, 1'b0, st);
        chk("mid_sb_not_empty", {31'd0, sb_empty}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("mid_reset_wr_en", {31'd0, dmem_wr_en}, 32'd0);
        chk("mid_reset_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("mid_reset_sb_empty", {31'd0, sb_empty}, 32'd1);
        idle(5);
        send(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b0, st);
        chk("mid_reset_load_stalls", st, 0);
        idle(2);

        // Idle dmem port is quiet
        chk("idle_wr_en", {31'd0, dmem_wr_en}, 32'd0);
        chk("idle_addr", {22'd0, dmem_addr}, 32'd0);
        chk("idle_sel", {28'd0, dmem_byte_sel}, 32'd0);
        chk("idle_data", dmem_data, 32'd0);

        idle(3);
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("wr_queue_drained", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit between the core's memory stage and riscv_dmem. It accepts byte-addressed RV32I load and store requests over a valid/ready handshake and checks alignment. Stores are posted into a small in-order store buffer and drained to the data memory in idle cycles. For loads, it reads the full word, extracts the addressed lane, sign- or zero-extends it, and returns the result one cycle later.

Parameters:
SB_DEPTH, 4, store buffer entries; power of two, at least 2
XLEN, `XLEN (32), data width
DMEM_ADDR_BIT, `DMEM_ADDR_BIT, byte-address width of data memory

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  reset, synchronous, active-low
i_req_valid  input  1  request valid
o_req_ready  output  1  request accepted when valid & ready
i_req_we  input  1  1 = store, 0 = load
i_req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
i_req_addr  input  XLEN  byte address
i_req_wdata  input  XLEN  store data, LSB-aligned
o_rsp_valid  output  1  one-cycle response pulse
o_rsp_rdata  output  XLEN  extended load data; 0 for stores and errors
o_rsp_err  output  1  misaligned or illegal funct3; valid with o_rsp_valid
o_sb_empty  output  1  store buffer empty (used by fence)
o_dmem_data  output  XLEN  write data to dmem
i_dmem_data  input  XLEN  combinational read data from dmem
o_dmem_addr  output  DMEM_ADDR_BIT-2  word address
o_dmem_byte_sel  output  XLEN/8  byte-lane mask
o_dmem_wr_en  output  1  write enable

Behaviour:
- Reset (i_rstn=0 at a rising edge): store buffer pointers and count go to 0, so pending stores are discarded. o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. While i_rstn=0: o_dmem_wr_en=0 and o_req_ready=0.
- Legality: funct3 000/100 any alignment. 001/101 need addr[0]=0. 010 needs addr[1:0]=0. Loads with 011/110/111 and stores with funct3>010 are illegal.
- Errored requests: accepted whenever valid. No buffer or dmem activity. Next cycle: o_rsp_valid=1, o_rsp_err=1, o_rsp_rdata=0.
- Store accept: ready = !full.
  - Push {word addr = addr[DMEM_ADDR_BIT-1:2], mask, data}.
  - mask is 0001/0011/1111 for SB/SH/SW, shifted left by addr[1:0].
  - data is wdata shifted left by 8*addr[1:0].
  - Next cycle: o_rsp_valid=1, err=0, rdata=0.
- Load accept: ready = no valid buffer entry has the same word address (word-granular hazard).
  - Accept cycle drives dmem addr=word addr, byte_sel=1111, wr_en=0.
  - Lane = i_dmem_data >> 8*addr[1:0]. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
  - The extended value is registered: o_rsp_valid=1 with o_rsp_rdata on the next cycle. Latency is exactly 1.
- Drain: only in cycles with no accepted request (valid & ready = 0) and the buffer non-empty.
  - Drive the head entry: wr_en=1, addr, byte_sel=mask, data.
  - Pop at that rising edge.
  - Drain never coincides with a push, so count never sees push and pop together.
- Progress: a full buffer or a load hazard deasserts ready, so the next cycle drains. Stalls always resolve.
- dmem outputs: when neither a load nor a drain is active, hold wr_en=0, byte_sel=0, addr=0, data=0.
- Ordering: stores reach dmem in program order. A load never bypasses a pending store to the same word, so no forwarding is needed.
- o_sb_empty = (count == 0), combinational.
- o_rsp_valid is a pulse; there is no backpressure on responses.

Test Plan:
- Reset: hold i_rstn=0 with stores pending -> o_rsp_valid=0, o_dmem_wr_en=0, o_sb_empty=1 after release.
- SW 0x80F17F02 @0x100, then idle -> one drain cycle with addr=0x40, byte_sel=1111. Then LB 0x101 -> 0x0000007F; LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080; LH 0x102 -> 0xFFFF80F1. Each response arrives 1 cycle after accept.
- SB 0xAB @0x105 -> drain byte_sel=0010, data=0x0000AB00. SH 0x1234 @0x106 -> byte_sel=1100, data=0x12340000.
- Back-to-back stores: SB_DEPTH+1 stores -> ready low on the 5th store until one drain. Then LW to the last stored word stalls until that entry drains, and returns the written value.
- Misaligned/illegal: LW @0x102, SH @0x101, load funct3=011 -> each accepted immediately, err=1, rdata=0, no dmem write.
- Mid-operation reset: 3 stores buffered, i_rstn=0 for 1 cycle -> none reach dmem (wr_en stays 0); o_sb_empty=1.
